wb_pipeline_reg: RTL and testbench
==================================

Name: wb_pipeline_reg

Overview:
- Parametrised MEM/WB pipeline register for the RISC-V pipeline. It sits between the memory stage and writeback.
- Replaces the single-flop, busy-wait-gated register with a valid/ready handshake and a 2-entry skid buffer. Upstream back-pressure is registered, so no combinational ready path runs across the stage.
- Adds synchronous flush (bubble insertion), write-enable gating by valid, and a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, width of ALU_RESULT, DATA_READED and PC_NEXT paths
- ADDR_W, 5, width of the destination register index
- SEL_W, 2, width of the MEM_TO_REG writeback-select field
- CNT_W, 16, width of STALL_COUNT

Ports:
- CLK  input  1  rising-edge clock, single clock domain
- RESET  input  1  synchronous, active-high reset
- FLUSH  input  1  synchronous; discards all held entries and any same-cycle input
- IN_VALID  input  1  upstream entry valid
- IN_READY  output  1  stage can accept an entry this cycle (registered)
- REG_WRITE  input  1  register-file write enable of incoming entry
- MEM_TO_REG  input  SEL_W  writeback source select
- IN_ADDRESS  input  ADDR_W  destination register index
- ALU_RESULT  input  DATA_W  ALU result
- DATA_READED  input  DATA_W  load data from memory
- PC_NEXT  input  DATA_W  PC+4 for link writes
- OUT_VALID  output  1  head entry valid
- OUT_READY  input  1  writeback consumes head entry this cycle
- REG_WRITE_OUT  output  1  head REG_WRITE AND OUT_VALID
- MEM_TO_REG_OUT  output  SEL_W  head field
- IN_ADDRESS_OUT  output  ADDR_W  head field
- ALU_RESULT_OUT  output  DATA_W  head field
- DATA_READED_OUT  output  DATA_W  head field
- PC_NEXT_OUT  output  DATA_W  head field
- STALL_COUNT  output  CNT_W  cycles with OUT_VALID=1 and OUT_READY=0, saturating

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. All state updates happen on the rising edge of CLK only.
- Priority on each edge: RESET > FLUSH > normal operation.
- Reset values:
  - OUT_VALID=0, REG_WRITE_OUT=0, IN_READY=1, STALL_COUNT=0.
  - All payload outputs = 0; skid entry invalid and zero.
- Storage: head register H drives the *_OUT ports. Skid register S holds one overflow entry.
- States (derived from the valid bits):
  - EMPTY (H and S invalid)
  - ONE (H valid, S invalid)
  - FULL (H and S valid)
- Definitions: accept = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY.
- Transitions:
  - EMPTY: accept -> load H, go to ONE; otherwise stay.
  - ONE, accept & pop: H <= input, stay ONE.
  - ONE, accept & !pop: S <= input, go to FULL.
  - ONE, !accept & pop: go to EMPTY (payload holds, valid clears).
  - ONE, otherwise: hold.
  - FULL, pop: H <= S, go to ONE. IN_READY is 0, so no accept is possible.
  - FULL, !pop: hold.
- IN_READY: registered, equal to !(next state == FULL). It is never 1 while S is valid, so no entry is ever dropped.
- Latency:
  - Accepted entry appears at the outputs on the edge that accepts it (OUT_VALID high the following cycle).
  - Full throughput of 1 entry/cycle when OUT_READY stays 1.
- Ordering: strict FIFO; S is always younger than H.
- FLUSH:
  - Both valids clear, next state = EMPTY, IN_READY=1.
  - Same-cycle input is not captured; same-cycle pop still counts as consumed.
  - Payload registers hold their values; REG_WRITE_OUT drops to 0 because it is gated by OUT_VALID.
- Safety rule: REG_WRITE_OUT must never be 1 while OUT_VALID is 0.
- STALL_COUNT:
  - Increments on every edge where OUT_VALID=1 and OUT_READY=0.
  - Saturates at 2^CNT_W-1 (no wrap). FLUSH does not clear it; only RESET does.
- Reset mid-operation: any held entries are lost, and outputs return to reset values on the next edge.

Test Plan:
- Reset, then continuous streaming: after RESET=1 for 2 cycles, drive OUT_READY=1 and IN_VALID=1 with entries ALU_RESULT=0x10,0x20,0x30 (REG_WRITE=1, IN_ADDRESS=5,6,7).
  - Required: the outputs show these entries in order on consecutive cycles, one cycle after each accept.
  - Required: IN_READY stays 1 throughout and STALL_COUNT=0.
- Back-pressure fill: OUT_READY=0 while presenting A (0xA), then B (0xB).
  - Required: the state reaches FULL and IN_READY=0 on the cycle after B is accepted; C (0xC) held on the input is not accepted.
  - Required: with OUT_READY=1 for 3 cycles, the outputs show A, B, C in order, with no entry lost or duplicated.
- Stall counter saturation: CNT_W=4, OUT_VALID held with OUT_READY=0 for 20 cycles.
  - Required: STALL_COUNT counts 1..15 and then holds at 15.
  - Required: only RESET returns it to 0.
- Flush while FULL: assert FLUSH together with IN_VALID=1 (ALU_RESULT=0xDEAD).
  - Required next cycle: OUT_VALID=0, REG_WRITE_OUT=0, IN_READY=1.
  - Required: 0xDEAD never appears at OUT_VALID=1.
- FLUSH and RESET asserted in the same cycle: the reset values apply, including STALL_COUNT=0.
- Reset mid-stream: assert RESET while in state ONE with REG_WRITE=1, IN_ADDRESS=9 at the head.
  - Required on the next edge: all outputs are zero, OUT_VALID=0 and IN_READY=1.
  - Required: a normal accept succeeds on the first cycle after RESET deasserts.

Source files
------------

// File: rtl/wb_pipeline_reg_if.sv
// ---------------------------------------------------------------------------
// wb_pipeline_reg_if
// Bundle of the MEM/WB stage boundary signals.
//   Upstream side  : FLUSH, IN_VALID/IN_READY handshake and the incoming entry
//                    (REG_WRITE, MEM_TO_REG, IN_ADDRESS, ALU_RESULT,
//                    DATA_READED, PC_NEXT).
//   Downstream side: OUT_VALID/OUT_READY handshake, the head entry (*_OUT)
//                    and the STALL_COUNT debug counter.
// Modports:
//   master - the surrounding pipeline (drives entries and OUT_READY)
//   slave  - the pipeline register itself
// ---------------------------------------------------------------------------
interface wb_pipeline_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic              FLUSH;
  logic              IN_VALID;
  logic              IN_READY;
  logic              REG_WRITE;
  logic [SEL_W-1:0]  MEM_TO_REG;
  logic [ADDR_W-1:0] IN_ADDRESS;
  logic [DATA_W-1:0] ALU_RESULT;
  logic [DATA_W-1:0] DATA_READED;
  logic [DATA_W-1:0] PC_NEXT;

  logic              OUT_VALID;
  logic              OUT_READY;
  logic              REG_WRITE_OUT;
  logic [SEL_W-1:0]  MEM_TO_REG_OUT;
  logic [ADDR_W-1:0] IN_ADDRESS_OUT;
  logic [DATA_W-1:0] ALU_RESULT_OUT;
  logic [DATA_W-1:0] DATA_READED_OUT;
  logic [DATA_W-1:0] PC_NEXT_OUT;
  logic [CNT_W-1:0]  STALL_COUNT;

  modport master (
    output FLUSH, IN_VALID, REG_WRITE, MEM_TO_REG, IN_ADDRESS,
           ALU_RESULT, DATA_READED, PC_NEXT, OUT_READY,
    input  IN_READY, OUT_VALID, REG_WRITE_OUT, MEM_TO_REG_OUT,
           IN_ADDRESS_OUT, ALU_RESULT_OUT, DATA_READED_OUT, PC_NEXT_OUT,
           STALL_COUNT
  );

  modport slave (
    input  FLUSH, IN_VALID, REG_WRITE, MEM_TO_REG, IN_ADDRESS,
           ALU_RESULT, DATA_READED, PC_NEXT, OUT_READY,
    output IN_READY, OUT_VALID, REG_WRITE_OUT, MEM_TO_REG_OUT,
           IN_ADDRESS_OUT, ALU_RESULT_OUT, DATA_READED_OUT, PC_NEXT_OUT,
           STALL_COUNT
  );
endinterface

// File: rtl/wb_pipeline_reg.sv
// ---------------------------------------------------------------------------
// wb_pipeline_reg
// MEM/WB pipeline register with valid/ready handshake and a 2-entry skid
// buffer (head H drives the outputs, skid S holds one younger entry).
// IN_READY is a flop, so upstream never sees a combinational path from
// OUT_READY. FLUSH drops both entries and ignores the same-cycle input.
// STALL_COUNT counts cycles with OUT_VALID=1 and OUT_READY=0, saturating.
// Ports:
//   CLK   - rising-edge clock
//   RESET - synchronous active-high reset (highest priority)
//   bus   - wb_pipeline_reg_if slave modport (handshakes, payloads, counter)
// ---------------------------------------------------------------------------
module wb_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  wb_pipeline_reg_if.slave    bus
);

  // Entry layout: {reg_write, mem_to_reg, address, alu, load data, pc_next}
  localparam int PAY_W = 1 + SEL_W + ADDR_W + 3 * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic               in_ready_reg;
  logic [PAY_W-1:0]   head_reg;
  logic [PAY_W-1:0]   skid_reg;
  logic [PAY_W-1:0]   in_payload;
  logic [CNT_W-1:0]   stall_cnt_reg;

  logic               accept;
  logic               pop;
  logic               out_valid;
  logic               load_head_in;
  logic               load_skid_in;
  logic               load_head_skid;

  assign in_payload = {bus.REG_WRITE, bus.MEM_TO_REG, bus.IN_ADDRESS,
                       bus.ALU_RESULT, bus.DATA_READED, bus.PC_NEXT};

  assign out_valid = (state_reg != EMPTY);
  assign accept    = bus.IN_VALID & in_ready_reg;
  assign pop       = out_valid & bus.OUT_READY;

  // State register. IN_READY is computed from the next state so that it is
  // already low on the cycle the skid entry becomes occupied.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != FULL);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (bus.FLUSH) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (accept) state_next = ONE;
        ONE: begin
          if (accept && !pop)      state_next = FULL;
          else if (!accept && pop) state_next = EMPTY;
        end
        FULL:    if (pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Datapath controls. A flush suppresses every load so the same-cycle input
  // is never captured and the payload registers simply hold.
  always_comb begin
    load_head_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_head_skid = 1'b0;
    if (!bus.FLUSH) begin
      case (state_reg)
        EMPTY: load_head_in = accept;
        ONE: begin
          load_head_in = accept & pop;
          load_skid_in = accept & ~pop;
        end
        FULL:    load_head_skid = pop;
        default: ;
      endcase
    end
  end

  // Payload registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_head_in)        head_reg <= in_payload;
      else if (load_head_skid) head_reg <= skid_reg;
      if (load_skid_in)        skid_reg <= in_payload;
    end
  end

  // Saturating stall counter; only RESET clears it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !bus.OUT_READY && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.IN_READY        = in_ready_reg;
  assign bus.OUT_VALID       = out_valid;
  // Write enable gated by valid so a bubble can never write the register file
  assign bus.REG_WRITE_OUT   = head_reg[PAY_W-1] & out_valid;
  assign bus.MEM_TO_REG_OUT  = head_reg[PAY_W-2 -: SEL_W];
  assign bus.IN_ADDRESS_OUT  = head_reg[3*DATA_W +: ADDR_W];
  assign bus.ALU_RESULT_OUT  = head_reg[2*DATA_W +: DATA_W];
  assign bus.DATA_READED_OUT = head_reg[DATA_W +: DATA_W];
  assign bus.PC_NEXT_OUT     = head_reg[0 +: DATA_W];
  assign bus.STALL_COUNT     = stall_cnt_reg;

endmodule

// File: tb/tb_wb_pipeline_reg.sv
module tb_wb_pipeline_reg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;
  localparam int VW     = 3 + SEL_W + ADDR_W + 3 * DATA_W + CNT_W;

  typedef logic [VW-1:0] vec_t;
  typedef struct packed {
    logic              rw;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] pc;
  } ent_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  wb_pipeline_reg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  wb_pipeline_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Reference model: a FIFO of capacity two, a ready flag, the last shown head
  ent_t             q[$];
  ent_t             shown;
  logic             m_ready;
  logic [CNT_W-1:0] m_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic vec_t exp_vec();
    logic v;
    v = (q.size() > 0);
    return {v, m_ready, shown.rw & v, shown.sel, shown.addr, shown.alu, shown.dr, shown.pc, m_cnt};
  endfunction

  function automatic vec_t dut_vec();
    return {bus.OUT_VALID, bus.IN_READY, bus.REG_WRITE_OUT, bus.MEM_TO_REG_OUT, bus.IN_ADDRESS_OUT,
            bus.ALU_RESULT_OUT, bus.DATA_READED_OUT, bus.PC_NEXT_OUT, bus.STALL_COUNT};
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.rw   = 1'($urandom);
    e.sel  = SEL_W'($urandom);
    e.addr = ADDR_W'($urandom);
    e.alu  = $urandom;
    e.dr   = $urandom;
    e.pc   = $urandom;
    return e;
  endfunction

  task automatic drive(input ent_t e);
    bus.REG_WRITE   = e.rw;
    bus.MEM_TO_REG  = e.sel;
    bus.IN_ADDRESS  = e.addr;
    bus.ALU_RESULT  = e.alu;
    bus.DATA_READED = e.dr;
    bus.PC_NEXT     = e.pc;
  endtask

  function automatic ent_t mk(input logic [DATA_W-1:0] alu, input logic [ADDR_W-1:0] addr);
    ent_t e;
    e = rand_ent();
    e.rw   = 1'b1;
    e.alu  = alu;
    e.addr = addr;
    return e;
  endfunction

  // One clock: sample the inputs, advance the model, settle 1 time unit.
  task automatic tick();
    logic rst, fl, ordy, acc, pop;
    ent_t inp;
    rst  = RESET;
    fl   = bus.FLUSH;
    ordy = bus.OUT_READY;
    inp  = {bus.REG_WRITE, bus.MEM_TO_REG, bus.IN_ADDRESS, bus.ALU_RESULT, bus.DATA_READED, bus.PC_NEXT};
    acc  = bus.IN_VALID && m_ready;
    pop  = (q.size() > 0) && ordy;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      m_ready = 1'b1;
      m_cnt   = '0;
      shown   = '0;
    end else begin
      if ((q.size() > 0) && !ordy && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
      if (fl) begin
        q.delete();
        m_ready = 1'b1;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(inp);
        m_ready = (q.size() < 2);
      end
      if (q.size() > 0) shown = q[0];
    end
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
    drive(rand_ent());
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL reset_vec got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({bus.OUT_VALID, bus.IN_READY, bus.REG_WRITE_OUT, bus.STALL_COUNT, bus.ALU_RESULT_OUT} !== {1'b0, 1'b1, 1'b0, 4'd0, 32'd0}) begin
      n_miss++; $display("FAIL reset_values got v=%b r=%b w=%b cnt=%0d alu=%h exp v=0 r=1 w=0 cnt=0 alu=0",
                         bus.OUT_VALID, bus.IN_READY, bus.REG_WRITE_OUT, bus.STALL_COUNT, bus.ALU_RESULT_OUT);
    end
    $display("reset: done");
    RESET = 1'b0;
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] a;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = DATA_W'(32'h10 * (i + 1));
      drive(mk(a, ADDR_W'(5 + i)));
      bus.IN_VALID = 1'b1;
      tick();
      n_vec++;
      if ({bus.OUT_VALID, bus.REG_WRITE_OUT, bus.ALU_RESULT_OUT, bus.IN_ADDRESS_OUT, bus.IN_READY, bus.STALL_COUNT}
          !== {1'b1, 1'b1, a, ADDR_W'(5 + i), 1'b1, 4'd0}) begin
        n_miss++; $display("FAIL stream_%0d got alu=%h addr=%0d v=%b r=%b cnt=%0d exp alu=%h addr=%0d v=1 r=1 cnt=0",
                           i, bus.ALU_RESULT_OUT, bus.IN_ADDRESS_OUT, bus.OUT_VALID, bus.IN_READY, bus.STALL_COUNT, a, 5 + i);
      end
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL stream_vec_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      $display("stream: entry %0d alu=%h out_alu=%h", i, a, bus.ALU_RESULT_OUT);
    end
    bus.IN_VALID = 1'b0;
    tick();
    n_vec++;
    if (bus.OUT_VALID !== 1'b0) begin
      n_miss++; $display("FAIL stream_drain got OUT_VALID=%b exp 0", bus.OUT_VALID);
    end
  endtask

  task automatic test_back_pressure();
    logic [DATA_W-1:0] exp_alu[3];
    exp_alu[0] = 32'hA; exp_alu[1] = 32'hB; exp_alu[2] = 32'hC;
    bus.OUT_READY = 1'b0;
    bus.IN_VALID  = 1'b1;
    drive(mk(32'hA, 5'd1)); tick();
    drive(mk(32'hB, 5'd2)); tick();
    n_vec++;
    if ({bus.IN_READY, bus.OUT_VALID, bus.ALU_RESULT_OUT} !== {1'b0, 1'b1, 32'hA}) begin
      n_miss++; $display("FAIL bp_full got r=%b v=%b alu=%h exp r=0 v=1 alu=a", bus.IN_READY, bus.OUT_VALID, bus.ALU_RESULT_OUT);
    end
    drive(mk(32'hC, 5'd3)); tick();
    n_vec++;
    if ({bus.IN_READY, bus.ALU_RESULT_OUT} !== {1'b0, 32'hA} || dut_vec() !== exp_vec()) begin
      n_miss++; $display("FAIL bp_hold_c got=%h exp=%h", dut_vec(), exp_vec());
    end
    bus.OUT_READY = 1'b1;
    for (int i = 1; i < 4; i++) begin
      if (i == 3) bus.IN_VALID = 1'b0;
      tick();
      n_vec++;
      if (i < 3 && {bus.OUT_VALID, bus.ALU_RESULT_OUT} !== {1'b1, exp_alu[i]}) begin
        n_miss++; $display("FAIL bp_order_%0d got v=%b alu=%h exp v=1 alu=%h", i, bus.OUT_VALID, bus.ALU_RESULT_OUT, exp_alu[i]);
      end else if (i == 3 && bus.OUT_VALID !== 1'b0) begin
        n_miss++; $display("FAIL bp_no_dup got OUT_VALID=%b exp 0", bus.OUT_VALID);
      end
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL bp_vec_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      $display("back_pressure: drain %0d v=%b alu=%h", i, bus.OUT_VALID, bus.ALU_RESULT_OUT);
    end
  endtask

  task automatic test_stall_saturation();
    logic [CNT_W-1:0] e;
    RESET = 1'b1; tick(); RESET = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.IN_VALID  = 1'b1; drive(mk(32'h77, 5'd4)); tick();
    bus.IN_VALID  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      e = (i > 15) ? 4'd15 : CNT_W'(i);
      n_vec++;
      if (bus.STALL_COUNT !== e) begin
        n_miss++; $display("FAIL stall_cnt_%0d got=%0d exp=%0d", i, bus.STALL_COUNT, e);
      end
      $display("stall: cycle %0d count=%0d", i, bus.STALL_COUNT);
    end
    bus.FLUSH = 1'b1; tick(); bus.FLUSH = 1'b0;
    n_vec++;
    if ({bus.STALL_COUNT, bus.OUT_VALID} !== {4'd15, 1'b0}) begin
      n_miss++; $display("FAIL stall_flush_keeps got cnt=%0d v=%b exp cnt=15 v=0", bus.STALL_COUNT, bus.OUT_VALID);
    end
    RESET = 1'b1; tick(); RESET = 1'b0;
    n_vec++;
    if (bus.STALL_COUNT !== 4'd0) begin
      n_miss++; $display("FAIL stall_reset got=%0d exp=0", bus.STALL_COUNT);
    end
  endtask

  task automatic test_flush();
    bus.OUT_READY = 1'b0;
    bus.IN_VALID  = 1'b1;
    drive(mk(32'h1111, 5'd10)); tick();
    drive(mk(32'h2222, 5'd11)); tick();
    bus.FLUSH = 1'b1; drive(mk(32'hDEAD, 5'd12)); tick();
    n_vec++;
    if ({bus.OUT_VALID, bus.REG_WRITE_OUT, bus.IN_READY} !== 3'b001 || dut_vec() !== exp_vec()) begin
      n_miss++; $display("FAIL flush_full got v=%b w=%b r=%b exp v=0 w=0 r=1", bus.OUT_VALID, bus.REG_WRITE_OUT, bus.IN_READY);
    end
    bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bus.OUT_VALID !== 1'b0 || (bus.OUT_VALID === 1'b1 && bus.ALU_RESULT_OUT === 32'hDEAD)) begin
        n_miss++; $display("FAIL flush_no_dead_%0d got v=%b alu=%h exp v=0", i, bus.OUT_VALID, bus.ALU_RESULT_OUT);
      end
    end
    // Flush in ONE while IN_READY=1: the same-cycle input must still be dropped
    bus.OUT_READY = 1'b0; bus.IN_VALID = 1'b1;
    drive(mk(32'h3333, 5'd13)); tick();
    bus.FLUSH = 1'b1; drive(mk(32'hDEAD, 5'd14)); tick();
    bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0; tick();
    n_vec++;
    if (bus.OUT_VALID !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_miss++; $display("FAIL flush_one_drop got=%h exp=%h", dut_vec(), exp_vec());
    end
    $display("flush: held alu=%h v=%b", bus.ALU_RESULT_OUT, bus.OUT_VALID);
  endtask

  task automatic test_flush_and_reset();
    bus.OUT_READY = 1'b0; bus.IN_VALID = 1'b1;
    drive(rand_ent()); tick();
    drive(rand_ent()); tick();
    bus.IN_VALID = 1'b0; tick();
    bus.FLUSH = 1'b1; RESET = 1'b1; tick();
    bus.FLUSH = 1'b0; RESET = 1'b0;
    n_vec++;
    if (dut_vec() !== {1'b0, 1'b1, {(VW-2){1'b0}}}) begin
      n_miss++; $display("FAIL flush_reset got=%h exp all zero except IN_READY", dut_vec());
    end
    $display("flush_and_reset: cnt=%0d", bus.STALL_COUNT);
  endtask

  task automatic test_reset_midstream();
    bus.OUT_READY = 1'b0; bus.IN_VALID = 1'b1;
    drive(mk(32'h4242, 5'd9)); tick();
    n_vec++;
    if ({bus.IN_ADDRESS_OUT, bus.REG_WRITE_OUT} !== {5'd9, 1'b1}) begin
      n_miss++; $display("FAIL mid_load got addr=%0d w=%b exp addr=9 w=1", bus.IN_ADDRESS_OUT, bus.REG_WRITE_OUT);
    end
    RESET = 1'b1; bus.IN_VALID = 1'b0; tick();
    n_vec++;
    if (dut_vec() !== {1'b0, 1'b1, {(VW-2){1'b0}}}) begin
      n_miss++; $display("FAIL mid_reset got=%h exp all zero except IN_READY", dut_vec());
    end
    RESET = 1'b0; bus.IN_VALID = 1'b1; drive(mk(32'h55, 5'd3)); tick();
    bus.IN_VALID = 1'b0;
    n_vec++;
    if ({bus.OUT_VALID, bus.ALU_RESULT_OUT, bus.IN_ADDRESS_OUT} !== {1'b1, 32'h55, 5'd3}) begin
      n_miss++; $display("FAIL mid_accept got v=%b alu=%h addr=%0d exp v=1 alu=55 addr=3",
                         bus.OUT_VALID, bus.ALU_RESULT_OUT, bus.IN_ADDRESS_OUT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RESET         = ($urandom_range(63) == 0);
      bus.FLUSH     = ($urandom_range(15) == 0);
      bus.IN_VALID  = ($urandom_range(3) != 0);
      bus.OUT_READY = ($urandom_range(2) != 0);
      drive(rand_ent());
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_miss++; $display("FAIL random_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      n_vec++;
      if (bus.REG_WRITE_OUT === 1'b1 && bus.OUT_VALID !== 1'b1) begin
        n_miss++; $display("FAIL random_safety_%0d got w=1 v=%b exp w=0 when v=0", i, bus.OUT_VALID);
      end
      if (i % 50 == 0) $display("random: cycle %0d depth=%0d cnt=%0d", i, q.size(), bus.STALL_COUNT);
    end
    RESET = 1'b0; bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
    drive('0);
    q.delete(); m_ready = 1'b1; m_cnt = '0; shown = '0;
    test_reset();
    test_stream();
    test_back_pressure();
    test_stall_saturation();
    test_flush();
    test_flush_and_reset();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
